// File: rtl/axi_sram_if.sv
// AXI3 read/write channel bundle between the CPU bridge master and the SRAM slave.
interface axi_sram_if;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, arlen, arsize, arburst, araddr, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awlen, awsize, awburst, awaddr, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, arlen, arsize, arburst, araddr, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awlen, awsize, awburst, awaddr, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving read/write bursts from one single-port synchronous SRAM,
// with round-robin read/write arbitration and one beat per cycle.
module axi_sram_slave #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              aclk,
    input  logic              aresetn,
    axi_sram_if.slave         bus,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        id_q, id_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              fixed_q, fixed_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rr_read_q, rr_read_d;

    logic [ADDR_W-1:0] ar_word, aw_word, addr_step;
    logic              last_beat, ar_grant, aw_grant;
    logic              unused_ok;

    assign ar_word   = bus.araddr[ADDR_W+1:2];
    assign aw_word   = bus.awaddr[ADDR_W+1:2];
    assign addr_step = fixed_q ? addr_q : addr_q + ADDR_W'(1);
    assign last_beat = (cnt_q == len_q);
    assign ar_grant  = bus.arvalid && (!bus.awvalid || rr_read_q);
    assign aw_grant  = bus.awvalid && (!bus.arvalid || !rr_read_q);
    assign unused_ok = ^{bus.arsize, bus.awsize, bus.wid,
                         bus.araddr[31:ADDR_W+2], bus.araddr[1:0],
                         bus.awaddr[31:ADDR_W+2], bus.awaddr[1:0]};

    // State and burst context registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            id_q      <= 4'd0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            fixed_q   <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            rr_read_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            fixed_q   <= fixed_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            rr_read_q <= rr_read_d;
        end
    end

    // Next state, channel handshakes and SRAM port control
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        fixed_d   = fixed_q;
        err_d     = err_q;
        addr_d    = addr_q;
        rr_read_d = rr_read_q;

        bus.arready = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        bus.bvalid  = 1'b0;
        bus.rid     = id_q;
        bus.bid     = id_q;
        bus.rdata   = ram_rdata;
        bus.rresp   = err_q ? RESP_SLVERR : RESP_OKAY;
        bus.bresp   = err_q ? RESP_SLVERR : RESP_OKAY;
        ram_en      = 1'b0;
        ram_we      = 4'd0;
        ram_addr    = addr_q;
        ram_wdata   = bus.wdata;

        unique case (state_q)
            IDLE: begin
                if (ar_grant) begin
                    // First read word is fetched in the handshake cycle itself
                    bus.arready = 1'b1;
                    ram_en      = 1'b1;
                    ram_addr    = ar_word;
                    id_d        = bus.arid;
                    len_d       = bus.arlen;
                    fixed_d     = (bus.arburst == BURST_FIXED);
                    err_d       = bus.arburst[1];
                    addr_d      = (bus.arburst == BURST_FIXED) ? ar_word : ar_word + ADDR_W'(1);
                    cnt_d       = 8'd0;
                    rr_read_d   = 1'b0;
                    state_d     = RD;
                end else if (aw_grant) begin
                    bus.awready = 1'b1;
                    id_d        = bus.awid;
                    len_d       = bus.awlen;
                    fixed_d     = (bus.awburst == BURST_FIXED);
                    err_d       = bus.awburst[1];
                    addr_d      = aw_word;
                    cnt_d       = 8'd0;
                    rr_read_d   = 1'b1;
                    state_d     = WR;
                end
            end
            RD: begin
                bus.rvalid = 1'b1;
                bus.rlast  = last_beat;
                if (bus.rready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        ram_en   = 1'b1;
                        ram_addr = addr_q;
                        addr_d   = addr_step;
                        cnt_d    = cnt_q + 8'd1;
                    end
                end
            end
            WR: begin
                bus.wready = 1'b1;
                if (bus.wvalid) begin
                    ram_en   = 1'b1;
                    ram_we   = bus.wstrb;
                    ram_addr = addr_q;
                    addr_d   = addr_step;
                    cnt_d    = cnt_q + 8'd1;
                    if (bus.wlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = WRESP;
                    end
                end
            end
            WRESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset wins over any handshake or SRAM write in the same cycle
        if (!aresetn) begin
            bus.arready = 1'b0;
            bus.awready = 1'b0;
            bus.wready  = 1'b0;
            bus.rvalid  = 1'b0;
            bus.rlast   = 1'b0;
            bus.bvalid  = 1'b0;
            ram_en      = 1'b0;
            ram_we      = 4'd0;
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural SRAM model.
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    axi_sram_if bus ();

    axi_sram_slave #(.ADDR_W(14)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .bus       (bus.slave),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 aclk = ~aclk;

    // SRAM model with clear and preload side ports
    logic [31:0] mem [0:16383];
    logic        mem_clr;
    logic        pre_we;
    logic [13:0] pre_addr;
    logic [31:0] pre_data;

    always @(posedge aclk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 32'd0;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_en) begin
            if (ram_we == 4'd0) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int to_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic next();
        @(posedge aclk);
        #1;
    endtask

    logic [31:0] rd_data [0:255];
    logic [31:0] wr_data [0:255];
    int          rd_cnt, rlast_idx, rlast_cnt, first_g, end_g, stable_bad, stall_en;
    logic [3:0]  last_rid, b_id;
    logic [1:0]  last_rresp, b_resp;
    logic        hs_en;
    logic [13:0] hs_addr;
    int          b_lat;

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int g = 0;
        bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr;
        bus.arlen = len; bus.arburst = burst; bus.arsize = 3'd2;
        #1;
        while (!bus.arready && g < 50) begin @(posedge aclk); #2; g++; end
        if (g >= 50) to_cnt++;
        hs_en = ram_en; hs_addr = ram_addr;
        next();
        bus.arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int g = 0;
        bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
        bus.awlen = len; bus.awburst = burst; bus.awsize = 3'd2;
        #1;
        while (!bus.awready && g < 50) begin @(posedge aclk); #2; g++; end
        if (g >= 50) to_cnt++;
        next();
        bus.awvalid = 1'b0;
    endtask

    task automatic w_send(input int n, input int wlast_idx);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            bus.wvalid = 1'b1; bus.wdata = wr_data[i]; bus.wstrb = 4'hF;
            bus.wlast = (i == wlast_idx); bus.wid = 4'd0;
            #1;
            while (!bus.wready && g < 50) begin @(posedge aclk); #2; g++; end
            if (g >= 50) to_cnt++;
            next();
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic b_wait();
        int g = 0;
        bus.bready = 1'b1;
        #1;
        while (!bus.bvalid && g < 50) begin @(posedge aclk); #2; g++; end
        if (g >= 50) to_cnt++;
        b_lat = g; b_resp = bus.bresp; b_id = bus.bid;
        next();
        bus.bready = 1'b0;
    endtask

    // Collects n beats; stall=1 drives rready as 1,0,0,1,0,0,...
    task automatic r_collect(input int n, input bit stall);
        int          g = 0;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_data = 32'd0;
        rd_cnt = 0; rlast_idx = -1; rlast_cnt = 0; first_g = -1;
        stable_bad = 0; stall_en = 0;
        while (rd_cnt < n && g < 1000) begin
            bus.rready = stall ? (g % 3 == 0) : 1'b1;
            #1;
            if (bus.rvalid && first_g < 0) first_g = g;
            if (bus.rvalid && prev_stall && bus.rdata !== prev_data) stable_bad++;
            if (bus.rvalid && !bus.rready && ram_en) stall_en++;
            prev_stall = bus.rvalid && !bus.rready;
            prev_data  = bus.rdata;
            if (bus.rvalid && bus.rready) begin
                rd_data[rd_cnt] = bus.rdata;
                last_rid = bus.rid; last_rresp = bus.rresp;
                if (bus.rlast) begin rlast_cnt++; if (rlast_idx < 0) rlast_idx = rd_cnt; end
                rd_cnt++;
            end
            next();
            g++;
        end
        if (g >= 1000) to_cnt++;
        end_g = g;
        bus.rready = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; mem_clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arburst = 0; bus.arsize = 0;
        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awburst = 0; bus.awsize = 0;
        bus.wvalid = 0; bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        bus.rready = 0; bus.bready = 0;
        next();
        mem_clr = 1'b0; pre_we = 1'b1; pre_addr = 14'h40; pre_data = 32'hDEADBEEF;
        next();
        pre_we = 1'b0;
        next();

        // Reset state, while held and just after release
        #1;
        check("rst_arready", 32'(bus.arready), 32'd0);
        check("rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("rst_ram_en",  32'(ram_en),      32'd0);
        aresetn = 1'b1;
        next();
        #1;
        check("idle_rvalid", 32'(bus.rvalid), 32'd0);
        check("idle_bvalid", 32'(bus.bvalid), 32'd0);
        check("idle_wready", 32'(bus.wready), 32'd0);
        check("idle_rid",    32'(bus.rid),    32'd0);
        check("idle_bid",    32'(bus.bid),    32'd0);
        check("idle_ram_en", 32'(ram_en),     32'd0);
        next();

        // Single read of word 0x40
        ar_send(4'd3, 32'h100, 8'd0, 2'b01);
        check("rd1_hs_en",   32'(hs_en),   32'd1);
        check("rd1_hs_addr", 32'(hs_addr), 32'h40);
        r_collect(1, 1'b0);
        check("rd1_latency", 32'(first_g),    32'd0);
        check("rd1_data",    rd_data[0],      32'hDEADBEEF);
        check("rd1_rid",     32'(last_rid),   32'd3);
        check("rd1_rlast",   32'(rlast_idx),  32'd0);
        check("rd1_rresp",   32'(last_rresp), 32'd0);

        // 16-beat INCR write then read back
        for (int i = 0; i < 16; i++) wr_data[i] = 32'(i);
        aw_send(4'd5, 32'h200, 8'd15, 2'b01);
        w_send(16, 15);
        b_wait();
        check("wr16_bresp", 32'(b_resp), 32'd0);
        check("wr16_bid",   32'(b_id),   32'd5);
        check("wr16_blat",  32'(b_lat),  32'd0);
        check("wr16_mem15", mem[14'h8F], 32'd15);
        ar_send(4'd6, 32'h200, 8'd15, 2'b01);
        r_collect(16, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("rd16_beat%0d", i), rd_data[i], 32'(i));
        check("rd16_rlast_idx", 32'(rlast_idx), 32'd15);
        check("rd16_rlast_cnt", 32'(rlast_cnt), 32'd1);
        check("rd16_cycles",    32'(end_g),     32'd16);
        check("rd16_rid",       32'(last_rid),  32'd6);

        // Backpressured 4-beat read
        ar_send(4'd2, 32'h204, 8'd3, 2'b01);
        r_collect(4, 1'b1);
        check("bp_count",  32'(rd_cnt),     32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("bp_beat%0d", i), rd_data[i], 32'(i + 1));
        check("bp_stable", 32'(stable_bad), 32'd0);
        check("bp_ram_en", 32'(stall_en),   32'd0);

        // WRAP read: INCR addressing, SLVERR response
        ar_send(4'd9, 32'h208, 8'd1, 2'b10);
        r_collect(2, 1'b0);
        check("wrap_beat1", rd_data[1],      32'd3);
        check("wrap_rresp", 32'(last_rresp), 32'd2);

        // Arbitration from reset with both requests pending
        aresetn = 1'b0;
        next();
        aresetn = 1'b1;
        bus.arvalid = 1'b1; bus.arid = 4'd1; bus.araddr = 32'h100; bus.arlen = 8'd0; bus.arburst = 2'b01;
        bus.awvalid = 1'b1; bus.awid = 4'd2; bus.awaddr = 32'h300; bus.awlen = 8'd0; bus.awburst = 2'b01;
        bus.rready = 1'b1;
        #1;
        check("arb_arready", 32'(bus.arready), 32'd1);
        check("arb_awready", 32'(bus.awready), 32'd0);
        next();
        #1;
        check("arb_rdata", bus.rdata, 32'hDEADBEEF);
        next();
        #1;
        check("arb2_awready", 32'(bus.awready), 32'd1);
        check("arb2_arready", 32'(bus.arready), 32'd0);
        next();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.rready = 1'b0;
        wr_data[0] = 32'hA5A5A5A5;
        w_send(1, 0);
        b_wait();
        check("arb_bid",  32'(b_id),     32'd2);
        check("arb_mem",  mem[14'hC0],   32'hA5A5A5A5);

        // FIXED 4-beat write to word 4
        for (int i = 0; i < 4; i++) wr_data[i] = 32'h11 * 32'(i + 1);
        aw_send(4'd3, 32'h10, 8'd3, 2'b00);
        w_send(4, 3);
        b_wait();
        check("fix_mem4",  mem[14'h4], 32'h44);
        check("fix_mem5",  mem[14'h5], 32'd0);
        check("fix_bresp", 32'(b_resp), 32'd0);

        // Early wlast on beat 1 of 4
        for (int i = 0; i < 4; i++) wr_data[i] = 32'h1000 + 32'(i);
        aw_send(4'd4, 32'h400, 8'd3, 2'b01);
        w_send(4, 1);
        b_wait();
        check("early_bresp", 32'(b_resp),  32'd2);
        check("early_blat",  32'(b_lat),   32'd0);
        check("early_mem3",  mem[14'h103], 32'h1003);

        // Reset during beat 5 of a 16-beat read
        ar_send(4'd7, 32'h200, 8'd15, 2'b01);
        for (int k = 0; k < 5; k++) begin
            bus.rready = 1'b1;
            #1;
            rd_data[k] = bus.rdata;
            next();
        end
        check("mid_beat4", rd_data[4], 32'd4);
        aresetn = 1'b0;
        next();
        aresetn = 1'b1; bus.rready = 1'b0;
        #1;
        check("mid_rvalid", 32'(bus.rvalid), 32'd0);
        check("mid_rid",    32'(bus.rid),    32'd0);
        check("mid_ram_en", 32'(ram_en),     32'd0);
        next();
        ar_send(4'd8, 32'h100, 8'd0, 2'b01);
        r_collect(1, 1'b0);
        check("post_rst_data", rd_data[0],    32'hDEADBEEF);
        check("post_rst_rid",  32'(last_rid), 32'd8);

        check("timeouts", 32'(to_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
